// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU cycle sequencer.
// State encoding, T-state bit positions and the M-cycle home position live
// here so that the sequencer and any microcode-side helpers agree on them.
package cpu_seq_pkg;

    // Sequencer modes. SEQ_PARK is only reachable when the single-step
    // debug feature is compiled in.
    typedef enum logic [1:0] {
        SEQ_RUN  = 2'd0,
        SEQ_WAIT = 2'd1,
        SEQ_HALT = 2'd2,
        SEQ_PARK = 2'd3
    } seq_state_e;

    // Number of T-states per M-cycle.
    localparam int STEP_W = 4;

    // Bit positions of each T-state inside the one-hot step vector.
    localparam int STEP_T1 = 0;
    localparam int STEP_T2 = 1;
    localparam int STEP_T3 = 2;
    localparam int STEP_T4 = 3;

    // Bit position of the first M-cycle of an instruction.
    localparam int COUNT_M0 = 0;

    // Default width of the one-hot M-cycle vector (legal range 2..8).
    localparam int MAX_MCYCLES_DEFAULT = 8;

endpackage

// File: rtl/onehot_ring.sv
// One-hot ring register.
// Resets and loads to bit 0; when enabled it rotates left by one, so the
// top bit wraps back to bit 0. Load has priority over rotate. WIDTH >= 2.
module onehot_ring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    output logic [WIDTH-1:0] ring
);

    // Ring register: home on reset/load, rotate left on enable, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values of the others.
        if (!rst_n) begin
            ring <= WIDTH'(1);
        end else if (load) begin
            ring <= WIDTH'(1);
        end else if (en) begin
            ring <= {ring[WIDTH-2:0], ring[WIDTH-1]};
        end
    end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// CPU cycle sequencer.
// Produces the one-hot T-state (o_Cycle_Step) and M-cycle (o_Cycle_Count)
// timing vectors for the microcode blocks, with memory wait stretching,
// HALT entry/exit and a sticky M-cycle overflow flag.
// Optional single-step debug parking is compiled in with the macro
// CPU_CYCLE_SEQ_SINGLE_STEP_EN (adds i_Dbg_Step_Mode, i_Dbg_Step,
// o_Dbg_Parked).
// MAX_MCYCLES must be 2..8; WAIT_STEP selects the T-state (0..3) in which
// i_Wait is honoured.
module cpu_cycle_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int MAX_MCYCLES = MAX_MCYCLES_DEFAULT,
    parameter int WAIT_STEP   = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_IR_Fetch,
    input  logic                   i_Wait,
    input  logic                   i_Halt_Req,
    input  logic                   i_Wake,
`ifdef CPU_CYCLE_SEQ_SINGLE_STEP_EN
    input  logic                   i_Dbg_Step_Mode,
    input  logic                   i_Dbg_Step,
    output logic                   o_Dbg_Parked,
`endif
    output logic [STEP_W-1:0]      o_Cycle_Step,
    output logic [MAX_MCYCLES-1:0] o_Cycle_Count,
    output logic                   o_Instr_Start,
    output logic                   o_Halted,
    output logic                   o_Seq_Error
);

    seq_state_e             state;
    seq_state_e             state_next;
    logic [STEP_W-1:0]      step;
    logic [MAX_MCYCLES-1:0] count;
    logic                   step_en;
    logic                   count_en;
    logic                   count_load;
    logic                   instr_start;
    logic                   start_next;
    logic                   seq_error;
    logic                   error_next;
    logic                   dbg_mode;
    logic                   dbg_release;

`ifdef CPU_CYCLE_SEQ_SINGLE_STEP_EN
    assign dbg_mode     = i_Dbg_Step_Mode;
    assign dbg_release  = i_Dbg_Step;
    assign o_Dbg_Parked = (state == SEQ_PARK);
`else
    assign dbg_mode    = 1'b0;
    assign dbg_release = 1'b0;
`endif

    // T-state ring: T1 -> T2 -> T3 -> T4 -> T1 whenever the sequencer advances.
    onehot_ring #(
        .WIDTH (STEP_W)
    ) u_step_ring (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .en    (step_en),
        .load  (1'b0),
        .ring  (step)
    );

    // M-cycle ring: rotates at T4 (overflow wraps to M0), reloads M0 on fetch.
    onehot_ring #(
        .WIDTH (MAX_MCYCLES)
    ) u_count_ring (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .en    (count_en),
        .load  (count_load),
        .ring  (count)
    );

    // Next-state logic: wait stretching, instruction boundary, HALT and park.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next = state;
        step_en    = 1'b0;
        count_en   = 1'b0;
        count_load = 1'b0;
        start_next = 1'b0;
        error_next = seq_error;

        case (state)
            SEQ_RUN, SEQ_WAIT: begin
                if (step[WAIT_STEP] && i_Wait) begin
                    // Bus not ready in the sampling T-state: hold step and count.
                    state_next = SEQ_WAIT;
                end else begin
                    state_next = SEQ_RUN;
                    step_en    = 1'b1;
                    if (step[STEP_T4]) begin
                        if (i_IR_Fetch) begin
                            // Instruction boundary: restart at M0.
                            count_load = 1'b1;
                            if (i_Halt_Req && !i_Wake) begin
                                state_next = SEQ_HALT;
                            end else if (dbg_mode) begin
                                state_next = SEQ_PARK;
                            end else begin
                                start_next = 1'b1;
                            end
                        end else begin
                            count_en = 1'b1;
                            if (count[MAX_MCYCLES-1]) begin
                                // Ran past the last M-cycle: wrap and flag it.
                                error_next = 1'b1;
                                if (dbg_mode) begin
                                    state_next = SEQ_PARK;
                                end else begin
                                    start_next = 1'b1;
                                end
                            end
                        end
                    end
                end
            end

            SEQ_HALT: begin
                // Frozen at T1/M0; an enabled interrupt restarts fetch.
                if (i_Wake) begin
                    state_next = SEQ_RUN;
                    start_next = 1'b1;
                end
            end

            SEQ_PARK: begin
                // Frozen at T1/M0; only a debug step pulse releases one instruction.
                if (dbg_release) begin
                    state_next = SEQ_RUN;
                    start_next = 1'b1;
                end
            end

            default: begin
                state_next = SEQ_RUN;
            end
        endcase
    end

    // Mode register, instruction-start pulse and sticky overflow flag.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= SEQ_RUN;
            instr_start <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            state       <= state_next;
            instr_start <= start_next;
            seq_error   <= error_next;
        end
    end

    assign o_Cycle_Step  = step;
    assign o_Cycle_Count = count;
    assign o_Instr_Start = instr_start;
    assign o_Halted      = (state == SEQ_HALT);
    assign o_Seq_Error   = seq_error;

endmodule
